// File: rtl/seq_mult.sv
// seq_mult: unsigned shift-and-add multiplier, one multiplier bit per clock.
// Takes N RUN cycles per operation, then a one-cycle DONE strobe that
// coincides with the freshly written product register.
module seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [2*N-1:0]   mcand;     // multiplicand, shifted left once per RUN cycle
  logic [N-1:0]     mplier;    // multiplier, shifted right once per RUN cycle
  logic [2*N-1:0]   acc;       // running partial sum
  logic [CW-1:0]    cnt;       // index of the multiplier bit being processed
  logic [2*N-1:0]   acc_sum;   // accumulator including the current bit
  logic             last_bit;  // this RUN cycle handles bit N-1

  // Partial-sum adder and end-of-operation detect.
  always_comb begin
    acc_sum  = acc + (mplier[0] ? mcand : '0);
    last_bit = (cnt == CW'(N - 1));
  end

  // State register; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, regardless of block order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned, which would
    // otherwise infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-and-add, and result write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // product only ever sees the finished sum, never intermediates.
          if (last_bit) product <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
